// File: rtl/cpu_pkg.sv
// Shared CPU constants and the IF/ID pipeline record.
package cpu_pkg;

    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    // PA-RISC NOP (OR 0,0,0)
    localparam logic [31:0] NOP_WORD = 32'h0800_0240;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/fetch_pc_queue_if.sv
// Fetch-stage bus: control inputs, ROM port and IF/ID outputs.
interface fetch_pc_queue_if #(
    parameter int PC_W   = 32,
    parameter int ROM_AW = 8,
    parameter int CNT_W  = 16
);

    logic              stall;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic              nullify;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic [PC_W-1:0]   pc_front;
    logic [PC_W-1:0]   pc_back;
    logic [31:0]       ifid_instr;
    logic [PC_W-1:0]   ifid_pc;
    logic              ifid_valid;
    logic [CNT_W-1:0]  fetch_cnt;

    // Fetch stage side
    modport slave (
        input  stall, br_taken, br_target, nullify, rom_data,
        output rom_addr, pc_front, pc_back, ifid_instr, ifid_pc, ifid_valid, fetch_cnt
    );

    // Pipeline control / ROM side
    modport master (
        output stall, br_taken, br_target, nullify, rom_data,
        input  rom_addr, pc_front, pc_back, ifid_instr, ifid_pc, ifid_valid, fetch_cnt
    );

endinterface

// File: rtl/ifid_reg.sv
// Generic pipeline register: holds when disabled, squashes to NOP when asked.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP = cpu_pkg::NOP_WORD
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  squash,
    input  ifid_t d,
    output ifid_t q
);

    // Capture on enable; a squashed slot becomes an invalid NOP but keeps its PC
    always_ff @(posedge clk) begin
        if (reset) begin
            q.instr <= NOP;
            q.pc    <= '0;
            q.valid <= 1'b0;
        end else if (en) begin
            q.instr <= squash ? NOP : d.instr;
            q.pc    <= d.pc;
            q.valid <= d.valid & ~squash;
        end
    end

endmodule

// File: rtl/fetch_pc_queue.sv
// Instruction fetch: PA-RISC PC queue (PC/nPC) with delayed branch,
// stall and nullify, feeding the IF/ID register from a combinational ROM.
module fetch_pc_queue #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              ROM_AW   = 8,
    parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0]     NOP_WORD = cpu_pkg::NOP_WORD,
    parameter int              CNT_W    = 16
) (
    input logic             clk,
    input logic             reset,
    fetch_pc_queue_if.slave bus
);

    logic [PC_W-1:0]  pc_front;
    logic [PC_W-1:0]  pc_back;
    logic [CNT_W-1:0] fetch_cnt;
    logic [PC_W-1:0]  next_back;
    cpu_pkg::ifid_t   ifid_d;
    cpu_pkg::ifid_t   ifid_q;

    // Branch target enters the back of the queue word-aligned; the old nPC
    // moves to the front, which is the delay slot.
    assign next_back = bus.br_taken ? {bus.br_target[PC_W-1:2], 2'b00}
                                    : pc_back + PC_W'(4);

    // PC queue advance; stall freezes it and any pending redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_front <= RESET_PC;
            pc_back  <= RESET_PC + PC_W'(4);
        end else if (!bus.stall) begin
            pc_front <= pc_back;
            pc_back  <= next_back;
        end
    end

    // Count real fetches, saturating at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
        end else if (!bus.stall && !bus.nullify && (fetch_cnt != '1)) begin
            fetch_cnt <= fetch_cnt + 1'b1;
        end
    end

    assign ifid_d.instr = bus.rom_data;
    assign ifid_d.pc    = pc_front;
    assign ifid_d.valid = 1'b1;

    ifid_reg #(.NOP(NOP_WORD)) u_ifid (
        .clk    (clk),
        .reset  (reset),
        .en     (~bus.stall),
        .squash (bus.nullify),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    // ROM address depends only on registered state
    assign bus.rom_addr   = pc_front[ROM_AW-1:0];
    assign bus.pc_front   = pc_front;
    assign bus.pc_back    = pc_back;
    assign bus.ifid_instr = ifid_q.instr;
    assign bus.ifid_pc    = ifid_q.pc;
    assign bus.ifid_valid = ifid_q.valid;
    assign bus.fetch_cnt  = fetch_cnt;

endmodule
